reset_seq_sync: RTL and testbench



---
 rtl/reset_seq_sync_if.sv | 24 ++
 rtl/reset_seq_sync.sv | 160 ++++++++++++++++
 tb/tb_reset_seq_sync.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_sync_if
// Purpose  : soft-reset request and sequenced reset outputs of reset_seq_sync.
//            The optional sw_rst_cnt signal exists only with RST_EVENT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface reset_seq_sync_if #(
  parameter int NUM_CH = 4
);
  logic              sw_rst_req;
  logic [NUM_CH-1:0] reset_syn;
  logic              rst_done;
`ifdef RST_EVENT_CNT_EN
  logic [7:0]        sw_rst_cnt;

  modport master (input sw_rst_req, output reset_syn, output rst_done, output sw_rst_cnt);
  modport slave  (output sw_rst_req, input reset_syn, input rst_done, input sw_rst_cnt);
`else
  modport master (input sw_rst_req, output reset_syn, output rst_done);
  modport slave  (output sw_rst_req, input reset_syn, input rst_done);
`endif
endinterface
`default_nettype wire

// File: rtl/reset_seq_sync.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_sync
// Purpose  : reset synchroniser and sequencer; releases NUM_CH active-low
//            resets in order. RST_EVENT_CNT_EN adds a soft-reset event counter.
// Revision : 1.0 - initial release
// ============================================================================
module reset_seq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int STRETCH_CYC = 16,
  parameter int GAP_CYC     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  reset_seq_sync_if.master bus
);

  localparam int c_max_cyc = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);
  localparam int c_idx_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [c_cnt_w-1:0] c_stretch_last = c_cnt_w'(STRETCH_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(GAP_CYC - 1);
  localparam logic [c_idx_w-1:0] c_idx_last     = c_idx_w'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync;

  state_t              r_state, w_state;
  logic [c_cnt_w-1:0]  r_cnt,   w_cnt;
  logic [c_idx_w-1:0]  r_idx,   w_idx;
  logic [NUM_CH-1:0]   r_syn,   w_syn;
  logic                r_done,  w_done;
  logic                w_accept;
  logic                w_rel_first;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_rst_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_syn   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_syn   <= w_syn;
      r_done  <= w_done;
    end
  end

  // The HOLD exit edge is the first stretch cycle, so STRETCH starts at count 1.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_syn       = r_syn;
    w_done      = r_done;
    w_rel_first = 1'b0;
    w_accept    = bus.sw_rst_req && (r_state != ST_HOLD);

    if (w_accept) begin
      w_state = ST_STRETCH;
      w_cnt   = '0;
      w_idx   = '0;
      w_syn   = '0;
      w_done  = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_rst_sync) begin
            if (STRETCH_CYC == 1) begin
              w_rel_first = 1'b1;
            end else begin
              w_state = ST_STRETCH;
              w_cnt   = c_cnt_w'(1);
            end
          end
        end
        ST_STRETCH: begin
          if (r_cnt == c_stretch_last) begin
            w_rel_first = 1'b1;
          end else begin
            w_cnt = r_cnt + c_cnt_w'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == c_gap_last) begin
            w_syn = r_syn | (NUM_CH'(1) << r_idx);
            w_cnt = '0;
            if (r_idx == c_idx_last) begin
              w_state = ST_DONE;
              w_done  = 1'b1;
            end else begin
              w_idx = r_idx + c_idx_w'(1);
            end
          end else begin
            w_cnt = r_cnt + c_cnt_w'(1);
          end
        end
        ST_DONE: begin
          w_state = ST_DONE;
        end
        default: begin
          w_state = ST_HOLD;
        end
      endcase

      if (w_rel_first) begin
        w_syn = r_syn | NUM_CH'(1);
        w_cnt = '0;
        if (NUM_CH == 1) begin
          w_state = ST_DONE;
          w_done  = 1'b1;
        end else begin
          w_state = ST_RELEASE;
          w_idx   = c_idx_w'(1);
        end
      end
    end
  end

  assign bus.reset_syn = r_syn;
  assign bus.rst_done  = r_done;

`ifdef RST_EVENT_CNT_EN
  logic [7:0] r_evt_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_cnt <= '0;
    end else if (w_accept && (r_evt_cnt != 8'hFF)) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign bus.sw_rst_cnt = r_evt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_seq_sync
// Purpose  : self-checking bench for reset_seq_sync (default and swept params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq_sync;

  localparam int S0 = 2, N0 = 4, ST0 = 16, G0 = 4;
  localparam int S1 = 3, N1 = 1, ST1 = 1,  G1 = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  reset_seq_sync_if #(.NUM_CH(N0)) bus0 ();
  reset_seq_sync_if #(.NUM_CH(N1)) bus1 ();

  reset_seq_sync #(.SYNC_STAGES(S0), .NUM_CH(N0), .STRETCH_CYC(ST0), .GAP_CYC(G0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  reset_seq_sync #(.SYNC_STAGES(S1), .NUM_CH(N1), .STRETCH_CYC(ST1), .GAP_CYC(G1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: edges since reset release, and the edge each sequence counts from.
  int n    = 0;
  int b0   = S0;
  int b1   = S1;
  int cnt0 = 0;
  int cnt1 = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n    <= 0;
      b0   <= S0;
      b1   <= S1;
      cnt0 <= 0;
      cnt1 <= 0;
    end else begin
      n <= n + 1;
      if (bus0.sw_rst_req && (n + 1 >= S0 + 2)) begin
        b0   <= n + 1;
        cnt0 <= (cnt0 < 255) ? cnt0 + 1 : 255;
      end
      if (bus1.sw_rst_req && (n + 1 >= S1 + 2)) begin
        b1   <= n + 1;
        cnt1 <= (cnt1 < 255) ? cnt1 + 1 : 255;
      end
    end
  end

  function automatic logic [31:0] exp_syn(input int edges, input int base,
                                          input int nch, input int st, input int gap);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nch; i++) begin
      if (edges >= base + st + i * gap) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_syn0", 32'(bus0.reset_syn), exp_syn(n, b0, N0, ST0, G0));
    chk("model_done0", 32'(bus0.rst_done), 32'(exp_syn(n, b0, N0, ST0, G0) == 32'hF));
    chk("model_syn1", 32'(bus1.reset_syn), exp_syn(n, b1, N1, ST1, G1));
    chk("model_done1", 32'(bus1.rst_done), exp_syn(n, b1, N1, ST1, G1));
`ifdef RST_EVENT_CNT_EN
    chk("model_cnt0", 32'(bus0.sw_rst_cnt), 32'(cnt0));
    chk("model_cnt1", 32'(bus1.sw_rst_cnt), 32'(cnt1));
`endif
  end

  task automatic step_to(input int k);
    int guard;
    guard = 0;
    while (n < k) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        $display("FAIL step_to: edge %0d not reached, stuck at %0d", k, n);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic lit0(input string name, input logic [3:0] syn, input logic done);
    chk({name, "_syn0"}, 32'(bus0.reset_syn), 32'(syn));
    chk({name, "_done0"}, 32'(bus0.rst_done), 32'(done));
  endtask

  task automatic lit1(input string name, input logic syn);
    chk({name, "_syn1"}, 32'(bus1.reset_syn), 32'(syn));
    chk({name, "_done1"}, 32'(bus1.rst_done), 32'(syn));
  endtask

  task automatic pulse0(input int r);
    step_to(r - 1);
    bus0.sw_rst_req = 1'b1;
    @(negedge clk);
    bus0.sw_rst_req = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    bus0.sw_rst_req = 1'b0;
    bus1.sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    lit0("in_reset", 4'b0000, 1'b0);
    lit1("in_reset", 1'b0);

    // Power-up with requests held high through HOLD and edges 1-2.
    bus0.sw_rst_req = 1'b1;
    bus1.sw_rst_req = 1'b1;
    #2 reset_n = 1'b1;
    step_to(2);
    bus0.sw_rst_req = 1'b0;
    bus1.sw_rst_req = 1'b0;
    step_to(3);
    lit1("pu_e3", 1'b0);
`ifdef RST_EVENT_CNT_EN
    chk("held_cnt0", 32'(bus0.sw_rst_cnt), 32'd0);
`endif
    step_to(4);  lit1("pu_e4", 1'b1);
    step_to(17); lit0("pu_e17", 4'b0000, 1'b0);
    step_to(18); lit0("pu_e18", 4'b0001, 1'b0);
    step_to(21); lit0("pu_e21", 4'b0001, 1'b0);
    step_to(22); lit0("pu_e22", 4'b0011, 1'b0);
    step_to(26); lit0("pu_e26", 4'b0111, 1'b0);
    step_to(29); lit0("pu_e29", 4'b0111, 1'b0);
    step_to(30); lit0("pu_e30", 4'b1111, 1'b1);

    // Soft reset in DONE, sampled at edge 35.
    pulse0(35);  lit0("sd_r",    4'b0000, 1'b0);
    step_to(50); lit0("sd_r15",  4'b0000, 1'b0);
    step_to(51); lit0("sd_r16",  4'b0001, 1'b0);
    step_to(62); lit0("sd_r27",  4'b0111, 1'b0);
    step_to(63); lit0("sd_r28",  4'b1111, 1'b1);
    lit1("sd_dut1_idle", 1'b1);

    // Short asynchronous reset pulse mid-cycle.
    step_to(70);
    #2 reset_n = 1'b0;
    #1 lit0("async", 4'b0000, 1'b0);
    lit1("async", 1'b0);
    #1 reset_n = 1'b1;
    step_to(17); lit0("ar_e17", 4'b0000, 1'b0);
    step_to(18); lit0("ar_e18", 4'b0001, 1'b0);
    step_to(23); lit0("ar_e23", 4'b0011, 1'b0);

    // Soft reset mid-sequence at edge 24.
    pulse0(24);  lit0("mid_e24", 4'b0000, 1'b0);
    step_to(39); lit0("mid_e39", 4'b0000, 1'b0);
    step_to(40); lit0("mid_e40", 4'b0001, 1'b0);
    step_to(51); lit0("mid_e51", 4'b0111, 1'b0);
    step_to(52); lit0("mid_e52", 4'b1111, 1'b1);

    // 300 back-to-back accepted requests on the single-channel instance.
    step_to(60);
    bus1.sw_rst_req = 1'b1;
    repeat (300) @(negedge clk);
    bus1.sw_rst_req = 1'b0;
    lit1("hold_last", 1'b0);
    @(negedge clk);
    lit1("hold_rel", 1'b1);
`ifdef RST_EVENT_CNT_EN
    chk("sat_cnt1", 32'(bus1.sw_rst_cnt), 32'd255);
    chk("sat_cnt0", 32'(bus0.sw_rst_cnt), 32'd1);
`endif
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
